// File: rtl/wide_add_sequencer_pkg.sv
// Shared definitions for the sequential wide adder: FSM encoding and adder slice width.
package wide_add_sequencer_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/wide_add_sequencer_cla.sv
// CLA_16: 16-bit carry-lookahead adder built from four 4-bit groups with group-level lookahead.
module CLA_16 (
    input  logic [15:0] X,
    input  logic [15:0] Y,
    input  logic        Cin,
    output logic [15:0] S,
    output logic        Cout
);

    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [3:0]  w_gg;
    logic [3:0]  w_gp;
    logic [16:0] w_c;

    assign w_g = X & Y;
    assign w_p = X ^ Y;

    always_comb begin
        w_gg = '0;
        w_gp = '0;
        w_c  = '0;
        for (int j = 0; j < 4; j++) begin
            w_gp[j] = &w_p[4*j +: 4];
            w_gg[j] = w_g[4*j+3]
                    | (w_p[4*j+3] & w_g[4*j+2])
                    | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                    | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
        end
        // Group carries are fully expanded so no group waits on its neighbour.
        w_c[0]  = Cin;
        w_c[4]  = w_gg[0] | (w_gp[0] & Cin);
        w_c[8]  = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & Cin);
        w_c[12] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                | (w_gp[2] & w_gp[1] & w_gp[0] & Cin);
        w_c[16] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & Cin);
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 3; i++) begin
                w_c[4*j+i+1] = w_g[4*j+i] | (w_p[4*j+i] & w_c[4*j+i]);
            end
        end
    end

    assign S    = w_p ^ w_c[15:0];
    assign Cout = w_c[16];

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract over one shared 16-bit CLA slice, LSB chunk first.
// Optional abort input enabled by defining WIDE_ADD_SEQUENCER_ABORT_EN.
module wide_add_sequencer
    import wide_add_sequencer_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SLICE = SLICE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef WIDE_ADD_SEQUENCER_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b_eff;
    logic               r_carry;

    logic [SLICE-1:0]   w_x;
    logic [SLICE-1:0]   w_y;
    logic [SLICE-1:0]   w_s;
    logic               w_co;
    logic               w_last;
    logic               w_abort;

`ifdef WIDE_ADD_SEQUENCER_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_x    = r_a[int'(r_idx)*SLICE +: SLICE];
    assign w_y    = r_b_eff[int'(r_idx)*SLICE +: SLICE];
    assign w_last = (r_idx == IDX_W'(NSLICE-1));

    CLA_16 u_slice (
        .X    (w_x),
        .Y    (w_y),
        .Cin  (r_carry),
        .S    (w_s),
        .Cout (w_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_a      <= '0;
            r_b_eff  <= '0;
            r_carry  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b and force the carry-in.
                        r_a     <= a;
                        r_b_eff <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        sum     <= '0;
                        r_idx   <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_abort) begin
                        sum      <= '0;
                        cout     <= 1'b0;
                        overflow <= 1'b0;
                        r_idx    <= '0;
                        busy     <= 1'b0;
                        r_state  <= IDLE;
                    end else begin
                        sum[int'(r_idx)*SLICE +: SLICE] <= w_s;
                        r_carry <= w_co;
                        r_idx   <= r_idx + 1'b1;
                        if (w_last) begin
                            // The MSB chunk is written at this same edge, so use the slice output.
                            cout     <= w_co;
                            overflow <= (r_a[WIDTH-1] == r_b_eff[WIDTH-1]) &&
                                        (w_s[SLICE-1] != r_a[WIDTH-1]);
                            done     <= 1'b1;
                            r_state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_idx   <= '0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_idx   <= '0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
Multi-cycle wide adder/subtractor that time-shares one 16-bit carry-lookahead adder slice across a WIDTH-bit operand pair.
- Processes one SLICE-bit chunk per clock, LSB chunk first, carrying between chunks in a register.
- Start/done handshake to the CPU datapath control; replaces a WIDTH-bit combinational adder where area matters more than latency.

Parameters:
- WIDTH, 64, operand/result width; must be an integer multiple of SLICE.
- SLICE, 16, chunk width fed to the shared adder slice; fixed at 16 for the current adder.
- NSLICE (localparam), WIDTH/SLICE, number of RUN cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  1 = a - b, 0 = a + b + cin.
- cin  in  1  carry-in for add; ignored when sub=1.
- a  in  WIDTH  operand A, latched on start accept.
- b  in  WIDTH  operand B, latched on start accept.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse, result valid.
- sum  out  WIDTH  result register.
- cout  out  1  carry out of MSB chunk; for sub, 1 = no borrow.
- overflow  out  1  signed overflow of the full-width result.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, slice index=0, carry reg=0, busy=0, done=0, sum=0, cout=0, overflow=0. Applies immediately, including mid-RUN; the operation in flight is lost.
- States:
  - IDLE: start=1 latches a, b_eff (b when sub=0, ~b when sub=1), carry reg (cin when sub=0, 1 when sub=1) and clears sum, then goes to RUN with idx=0.
  - RUN: the shared slice adds a[idx chunk] + b_eff[idx chunk] + carry reg. Its output is written to sum[idx chunk] and its carry-out to carry reg. idx increments each cycle; after idx=NSLICE-1 the state goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Timing (default NSLICE=4): start in cycle 0 → RUN cycles 1–4 → done=1 in cycle 5 → busy=0 in cycle 6. Start-to-done latency is NSLICE+1 cycles.
- cout = final carry reg, registered when leaving RUN.
- overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), registered at the same edge as cout.
- sum, cout and overflow hold their values until the next start is accepted.
- start while busy=1 is ignored, not queued. The next start is accepted no earlier than the cycle busy reads 0.
- Operand ports are don't-care except in the accept cycle.
- No combinational path from any input to any output.

Optional Feature:
- Macro: WIDE_ADD_SEQUENCER_ABORT_EN.
- With the macro: extra input port abort (1 bit). abort=1 in RUN moves to IDLE at the next edge with sum=0, cout=0, overflow=0 and no done pulse. abort is ignored in IDLE and DONE. If abort and the last RUN cycle coincide, abort wins.
- Without the macro: port absent; RUN always completes.

Decomposition:
- Shared package holds:
  - the state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - SLICE_W=16.
- One sub-module: the team's existing 16-bit carry-lookahead adder CLA_16 (ports X, Y, Cin, S, Cout), instantiated once as the shared slice.
- Chunk muxing, carry register and FSM stay in wide_add_sequencer.

Test Plan:
- Chunk carry propagation: a=64'h0000_0000_0000_FFFF, b=1, sub=0, cin=0, start in cycle 0 → busy high cycles 1–5, done only in cycle 5, sum=64'h0000_0000_0001_0000, cout=0, overflow=0.
- Full wrap: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1 → sum=0, cout=1, overflow=0.
- Subtract with borrow: a=5, b=7, sub=1 → sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0, overflow=0. Then a=7, b=5 → sum=2, cout=1.
- Signed overflow: a=64'h7FFF_FFFF_FFFF_FFFF, b=1, sub=0 → sum=64'h8000_0000_0000_0000, overflow=1, cout=0.
- Start while busy: second start with different operands in cycle 2 → ignored; first result unchanged; exactly one done pulse.
- Reset mid-RUN: rst_n low in cycle 3 → all outputs 0 immediately. After release, a fresh start completes normally with correct sum.
